// File: rtl/regfile_writer_if.sv
// regfile_writer_if: producer handshakes, register-file write port and forwarding query bundle.
interface regfile_writer_if #(parameter int XLEN = 32);
    logic            alu_valid, alu_ready, ld_valid, ld_ready;
    logic [4:0]      alu_rd, ld_rd, rd, fwd_rs1, fwd_rs2;
    logic [XLEN-1:0] alu_data, ld_data, rd_v, fwd_v1, fwd_v2;
    logic            wen, fwd_hit1, fwd_hit2, busy;
    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, fwd_rs1, fwd_rs2,
        input  alu_ready, ld_ready, wen, rd, rd_v, fwd_hit1, fwd_hit2, fwd_v1, fwd_v2, busy
    );
    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, fwd_rs1, fwd_rs2,
        output alu_ready, ld_ready, wen, rd, rd_v, fwd_hit1, fwd_hit2, fwd_v1, fwd_v2, busy
    );
endinterface

// File: rtl/regfile_writer.sv
// regfile_writer: in-order write-back FIFO merging ALU and load results into one register-file write port.
// Define REGFILE_WRITER_FWD_EN to build the forwarding lookup; otherwise the forwarding outputs are tied to 0.
module regfile_writer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    regfile_writer_if.slave rf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0] FULL_M1 = (AW+1)'(DEPTH - 1);

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [AW-1:0]   head_q, head_d, tail_q, tail_d, alu_slot;
    logic [AW:0]     count_q, count_d;
    logic            wen_q, wen_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] rd_v_q, rd_v_d;
    logic            ld_ready, alu_ready, ld_push, alu_push, pop;

    // Readies use the start-of-cycle count only; a same-cycle pop never frees a slot.
    assign ld_ready  = count_q != FULL;
    assign alu_ready = (count_q < FULL_M1) || (count_q == FULL_M1 && !rf.ld_valid);
    assign ld_push   = rf.ld_valid && ld_ready && rf.ld_rd != 5'd0;
    assign alu_push  = rf.alu_valid && alu_ready && rf.alu_rd != 5'd0;
    assign pop       = count_q != '0;
    assign alu_slot  = ld_push ? tail_q + AW'(1) : tail_q;

    always_comb begin
        mem_d = mem_q;
        if (ld_push) mem_d[tail_q] = '{rd: rf.ld_rd, data: rf.ld_data};
        if (alu_push) mem_d[alu_slot] = '{rd: rf.alu_rd, data: rf.alu_data};
        tail_d  = tail_q + AW'(ld_push) + AW'(alu_push);
        head_d  = head_q + AW'(pop);
        count_d = count_q + (AW+1)'(ld_push) + (AW+1)'(alu_push) - (AW+1)'(pop);
        wen_d   = pop;
        rd_d    = pop ? mem_q[head_q].rd : rd_q;
        rd_v_d  = pop ? mem_q[head_q].data : rd_v_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            wen_q   <= 1'b0;
            rd_q    <= '0;
            rd_v_q  <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            wen_q   <= wen_d;
            rd_q    <= rd_d;
            rd_v_q  <= rd_v_d;
        end
    end

    assign rf.ld_ready  = ld_ready;
    assign rf.alu_ready = alu_ready;
    assign rf.wen       = wen_q;
    assign rf.rd        = rd_q;
    assign rf.rd_v      = rd_v_q;
    assign rf.busy      = pop || wen_q;

`ifdef REGFILE_WRITER_FWD_EN
    logic [XLEN:0] fwd1, fwd2;

    // Scan oldest to youngest so the youngest match overwrites earlier ones.
    function automatic logic [XLEN:0] lookup(input logic [4:0] q);
        logic [XLEN:0] r;
        logic [AW-1:0] idx;
        r = (wen_q && rd_q == q) ? {1'b1, rd_v_q} : '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + AW'(i);
            if (i < int'(count_q) && mem_q[idx].rd == q) r = {1'b1, mem_q[idx].data};
        end
        return (q == 5'd0) ? '0 : r;
    endfunction

    always_comb begin
        fwd1 = lookup(rf.fwd_rs1);
        fwd2 = lookup(rf.fwd_rs2);
    end

    assign {rf.fwd_hit1, rf.fwd_v1} = fwd1;
    assign {rf.fwd_hit2, rf.fwd_v2} = fwd2;
`else
    logic unused_fwd;
    assign unused_fwd  = ^{rf.fwd_rs1, rf.fwd_rs2};
    assign rf.fwd_hit1 = 1'b0;
    assign rf.fwd_hit2 = 1'b0;
    assign rf.fwd_v1   = '0;
    assign rf.fwd_v2   = '0;
`endif
endmodule
